// File: rtl/zx_mem_pager.sv
// 128K/+2A-style memory pager for the Spectrum host board: latches the paging
// ports from Z80 I/O writes and maps each CPU address onto a ROM or RAM bank.
module zx_mem_pager #(
  parameter int          RAM_BANKS   = 8,
  parameter int          ROM_BANKS   = 2,
  parameter int          EXT_PORT_EN = 0,
  parameter logic [15:0] P7_MASK     = 16'hC002,
  parameter logic [15:0] P7_MATCH    = 16'h4000,
  parameter logic [15:0] P1_MASK     = 16'hF002,
  parameter logic [15:0] P1_MATCH    = 16'h1000,
  localparam int         RAM_BW      = $clog2(RAM_BANKS),
  localparam int         ROM_BW      = $clog2(ROM_BANKS)
) (
  input  logic              clk_vram,
  input  logic              reset,
  input  logic [15:0]       A,
  input  logic [7:0]        D,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic              nM1,
  output logic              mem_rom,
  output logic [ROM_BW-1:0] rom_bank,
  output logic [RAM_BW-1:0] ram_bank,
  output logic [13:0]       mem_offset,
  output logic              mem_we,
  output logic              screen_bank,
  output logic [7:0]        page_7ffd,
  output logic [7:0]        page_1ffd,
  output logic              locked,
  output logic              page_evt
);

  logic       io_wr, io_wr_q;
  logic       rst_mask_q;
  logic       wr_stb, ld7, ld1;
  logic [7:0] p7_q, p7_d;
  logic [7:0] p1_q, p1_d;
  logic       evt_q, evt_d;

  // Reads need no decoding here; the ROM/RAM instances use nRD directly.
  logic unused_inputs;
  assign unused_inputs = nRD;

  assign io_wr = !nIORQ && !nWR && nM1;

  // The first cycle after reset treats io_wr_q as high, so a write still in
  // progress when reset releases never produces a strobe.
  assign wr_stb = io_wr && !io_wr_q && !rst_mask_q;

  assign ld7 = wr_stb && !p7_q[5] && ((A & P7_MASK) == P7_MATCH);
  assign ld1 = wr_stb && !p7_q[5] && (EXT_PORT_EN != 0) && ((A & P1_MASK) == P1_MATCH);

  assign p7_d  = ld7 ? D : p7_q;
  assign p1_d  = ld1 ? D : p1_q;
  assign evt_d = ld7 || ld1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_vram or posedge reset) begin
    if (reset) begin
      rst_mask_q <= 1'b1;
      io_wr_q    <= 1'b0;
      p7_q       <= 8'h00;
      p1_q       <= 8'h00;
      evt_q      <= 1'b0;
    end else begin
      rst_mask_q <= 1'b0;
      io_wr_q    <= io_wr;
      p7_q       <= p7_d;
      p1_q       <= p1_d;
      evt_q      <= evt_d;
    end
  end

  logic [4:0] ram_sel;
  logic [1:0] rom_sel;
  logic [2:0] spec_bank;

  assign ram_sel = {p7_q[7:6], p7_q[2:0]};
  assign rom_sel = {p1_q[2], p7_q[4]};

  // All-RAM layouts, indexed by {page_1ffd[2:1], slot}.
  always_comb begin
    spec_bank = 3'd0;
    case ({p1_q[2:1], A[15:14]})
      4'b00_00: spec_bank = 3'd0;
      4'b00_01: spec_bank = 3'd1;
      4'b00_10: spec_bank = 3'd2;
      4'b00_11: spec_bank = 3'd3;
      4'b01_00: spec_bank = 3'd4;
      4'b01_01: spec_bank = 3'd5;
      4'b01_10: spec_bank = 3'd6;
      4'b01_11: spec_bank = 3'd7;
      4'b10_00: spec_bank = 3'd4;
      4'b10_01: spec_bank = 3'd5;
      4'b10_10: spec_bank = 3'd6;
      4'b10_11: spec_bank = 3'd3;
      4'b11_00: spec_bank = 3'd4;
      4'b11_01: spec_bank = 3'd7;
      4'b11_10: spec_bank = 3'd6;
      default:  spec_bank = 3'd3;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    mem_rom  = 1'b0;
    rom_bank = ROM_BW'(rom_sel);
    ram_bank = '0;
    if (p1_q[0]) begin
      ram_bank = RAM_BW'(spec_bank);
    end else begin
      case (A[15:14])
        2'b00:   mem_rom  = 1'b1;
        2'b01:   ram_bank = RAM_BW'(5);
        2'b10:   ram_bank = RAM_BW'(2);
        default: ram_bank = RAM_BW'(ram_sel);
      endcase
    end
  end

  assign mem_offset  = A[13:0];
  assign mem_we      = !nMREQ && !nWR && !mem_rom;
  assign screen_bank = p7_q[3];
  assign page_7ffd   = p7_q;
  assign page_1ffd   = p1_q;
  assign locked      = p7_q[5];
  assign page_evt    = evt_q;

endmodule

// File: tb/tb_zx_mem_pager.sv
// Self-checking bench for zx_mem_pager: a default 48K/128K instance and an
// extended instance (32 RAM banks, 4 ROM banks, secondary port) share one bus.
module tb_zx_mem_pager;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  D;
  logic        nMREQ, nIORQ, nRD, nWR, nM1;

  logic        rom0, we0, sb0, lk0, pe0;
  logic [0:0]  rb0;
  logic [2:0]  mb0;
  logic [13:0] off0;
  logic [7:0]  p7_0, p1_0;

  logic        rom1, we1, sb1, lk1, pe1;
  logic [1:0]  rb1;
  logic [4:0]  mb1;
  logic [13:0] off1;
  logic [7:0]  p7_1, p1_1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  zx_mem_pager dut0 (
    .clk_vram(clk), .reset(reset), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .mem_rom(rom0), .rom_bank(rb0), .ram_bank(mb0), .mem_offset(off0),
    .mem_we(we0), .screen_bank(sb0), .page_7ffd(p7_0), .page_1ffd(p1_0),
    .locked(lk0), .page_evt(pe0)
  );

  zx_mem_pager #(.RAM_BANKS(32), .ROM_BANKS(4), .EXT_PORT_EN(1)) dut1 (
    .clk_vram(clk), .reset(reset), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .mem_rom(rom1), .rom_bank(rb1), .ram_bank(mb1), .mem_offset(off1),
    .mem_we(we1), .screen_bank(sb1), .page_7ffd(p7_1), .page_1ffd(p1_1),
    .locked(lk1), .page_evt(pe1)
  );

  // Reference model: register contents per instance plus the paging rules.
  logic [7:0] mp7 [2];
  logic [7:0] mp1 [2];
  int ram_n [2] = '{8, 32};
  int rom_n [2] = '{2, 4};
  int ext_n [2] = '{0, 1};
  int spec_tbl [4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};

  function automatic void model_map(input int k, input logic [15:0] a,
                                    output bit rom, output int rb, output int mb);
    int slot;
    slot = int'(a[15:14]);
    rom = 1'b0;
    rb  = 0;
    mb  = 0;
    if (mp1[k][0]) begin
      mb = spec_tbl[int'(mp1[k][2:1])][slot];
    end else if (slot == 0) begin
      rom = 1'b1;
      rb  = (rom_n[k] == 4) ? 2 * int'(mp1[k][2]) + int'(mp7[k][4]) : int'(mp7[k][4]);
    end else if (slot == 1) begin
      mb = 5;
    end else if (slot == 2) begin
      mb = 2;
    end else begin
      mb = (int'(mp7[k][7:6]) * 8 + int'(mp7[k][2:0])) % ram_n[k];
    end
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d,
                                      input logic m1, output int exp0, output int exp1);
    int e [2];
    for (int k = 0; k < 2; k++) begin
      bit h7, h1;
      e[k] = 0;
      h7 = ((a & 16'hC002) == 16'h4000);
      h1 = (ext_n[k] != 0) && ((a & 16'hF002) == 16'h1000);
      if (m1 && !mp7[k][5] && (h7 || h1)) begin
        if (h7) mp7[k] = d;
        if (h1) mp1[k] = d;
        e[k] = 1;
      end
    end
    exp0 = e[0];
    exp1 = e[1];
  endfunction

  task automatic bus_idle();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_idle();
    A = 16'h0000; D = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mp7[k] = 8'h00;
      mp1[k] = 8'h00;
    end
  endtask

  // Drives one OUT cycle with io_wr held for cyc clocks; counts page_evt
  // pulses per instance and samples inst1 mem_rom before the load edge.
  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int cyc,
                          input logic m1, output int evt0, output int evt1,
                          output logic pre_rom1);
    @(negedge clk);
    A = a; D = d; nMREQ = 1'b1; nRD = 1'b1;
    nIORQ = 1'b0; nWR = 1'b0; nM1 = m1;
    #1 pre_rom1 = rom1;
    evt0 = 0;
    evt1 = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      evt0 += int'(pe0);
      evt1 += int'(pe1);
    end
    bus_idle();
    @(negedge clk);
    evt0 += int'(pe0);
    evt1 += int'(pe1);
  endtask

  task automatic mem_access(input logic [15:0] a, input logic wr);
    @(negedge clk);
    A = a; nIORQ = 1'b1; nM1 = 1'b1; nMREQ = 1'b0;
    nWR = !wr; nRD = wr;
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] addrs [4] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    logic        exp_rom [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int          exp_bank [4] = '{0, 5, 2, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_access(addrs[i], 1'b0);
      n_cmp++;
      if (rom0 !== exp_rom[i]) begin
        n_bad++; $display("FAIL reset_rom A=%h got %b want %b", addrs[i], rom0, exp_rom[i]);
      end
      if (!exp_rom[i]) begin
        n_cmp++;
        if (int'(mb0) != exp_bank[i]) begin
          n_bad++; $display("FAIL reset_bank A=%h got %0d want %0d", addrs[i], mb0, exp_bank[i]);
        end
      end else begin
        n_cmp++;
        if (rb0 !== 1'b0) begin
          n_bad++; $display("FAIL reset_rom_bank got %0d want 0", rb0);
        end
      end
    end
    n_cmp++;
    if ({sb0, lk0, pe0, p7_0, p1_1} !== 19'd0) begin
      n_bad++; $display("FAIL reset_regs got sb=%b lk=%b pe=%b p7=%h p1=%h want all 0",
                        sb0, lk0, pe0, p7_0, p1_1);
    end
  endtask

  task automatic test_basic_page();
    int e0, e1;
    logic pr;
    do_reset();
    io_write(16'h7FFD, 8'h1F, 3, 1'b1, e0, e1, pr);
    n_cmp++;
    if (e0 != 1 || e1 != 1) begin
      n_bad++; $display("FAIL basic_evt got %0d/%0d want 1/1", e0, e1);
    end
    mem_access(16'hC000, 1'b0);
    n_cmp++;
    if (rom0 !== 1'b0 || mb0 !== 3'd7) begin
      n_bad++; $display("FAIL basic_c000 got rom=%b bank=%0d want rom=0 bank=7", rom0, mb0);
    end
    mem_access(16'h0000, 1'b0);
    n_cmp++;
    if (rom0 !== 1'b1 || rb0 !== 1'b1 || rb1 !== 2'd1) begin
      n_bad++; $display("FAIL basic_rom got rom=%b rb=%0d/%0d want 1 1/1", rom0, rb0, rb1);
    end
    n_cmp++;
    if (sb0 !== 1'b1 || lk0 !== 1'b0) begin
      n_bad++; $display("FAIL basic_flags got sb=%b lk=%b want sb=1 lk=0", sb0, lk0);
    end
  endtask

  task automatic test_lock();
    int e0, e1;
    logic pr;
    do_reset();
    io_write(16'h7FFD, 8'h20, 1, 1'b1, e0, e1, pr);
    n_cmp++;
    if (e0 != 1 || lk0 !== 1'b1) begin
      n_bad++; $display("FAIL lock_set got evt=%0d lk=%b want evt=1 lk=1", e0, lk0);
    end
    io_write(16'h7FFD, 8'h03, 2, 1'b1, e0, e1, pr);
    n_cmp++;
    if (e0 != 0 || e1 != 0) begin
      n_bad++; $display("FAIL lock_evt got %0d/%0d want 0/0", e0, e1);
    end
    n_cmp++;
    if (p7_0 !== 8'h20) begin
      n_bad++; $display("FAIL lock_reg got %h want 20", p7_0);
    end
    mem_access(16'hC000, 1'b0);
    n_cmp++;
    if (mb0 !== 3'd0) begin
      n_bad++; $display("FAIL lock_c000 got %0d want 0", mb0);
    end
  endtask

  task automatic test_bank_sel();
    int e0, e1;
    logic pr;
    do_reset();
    io_write(16'h7FFD, 8'hC7, 1, 1'b1, e0, e1, pr);
    mem_access(16'hC000, 1'b0);
    n_cmp++;
    if (mb0 !== 3'd7) begin
      n_bad++; $display("FAIL sel_8banks got %0d want 7", mb0);
    end
    n_cmp++;
    if (mb1 !== 5'd31) begin
      n_bad++; $display("FAIL sel_32banks got %0d want 31", mb1);
    end
  endtask

  task automatic test_ext();
    int e0, e1;
    logic pr;
    logic [15:0] addrs [4] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    int exp_bank [4] = '{4, 7, 6, 3};
    do_reset();
    io_write(16'h1FFD, 8'h07, 2, 1'b1, e0, e1, pr);
    n_cmp++;
    if (pr !== 1'b1) begin
      n_bad++; $display("FAIL ext_old_map got rom=%b want 1", pr);
    end
    n_cmp++;
    if (e0 != 0 || e1 != 1 || p1_0 !== 8'h00 || p1_1 !== 8'h07) begin
      n_bad++; $display("FAIL ext_load got evt=%0d/%0d p1=%h/%h want 0/1 00/07", e0, e1, p1_0, p1_1);
    end
    for (int i = 0; i < 4; i++) begin
      mem_access(addrs[i], 1'b0);
      n_cmp++;
      if (rom1 !== 1'b0 || int'(mb1) != exp_bank[i]) begin
        n_bad++; $display("FAIL ext_slot A=%h got rom=%b bank=%0d want rom=0 bank=%0d",
                          addrs[i], rom1, mb1, exp_bank[i]);
      end
    end
    mem_access(16'h0000, 1'b1);
    n_cmp++;
    if (we1 !== 1'b1 || we0 !== 1'b0) begin
      n_bad++; $display("FAIL ext_we got %b/%b want 0/1", we0, we1);
    end
    io_write(16'h1FFD, 8'h04, 1, 1'b1, e0, e1, pr);
    mem_access(16'h0000, 1'b0);
    n_cmp++;
    if (rom1 !== 1'b1 || rb1 !== 2'd2) begin
      n_bad++; $display("FAIL ext_rom2 got rom=%b rb=%0d want rom=1 rb=2", rom1, rb1);
    end
  endtask

  task automatic test_rom_write();
    do_reset();
    mem_access(16'h0100, 1'b1);
    n_cmp++;
    if (we0 !== 1'b0) begin
      n_bad++; $display("FAIL rom_we got %b want 0", we0);
    end
    mem_access(16'h4100, 1'b1);
    n_cmp++;
    if (we0 !== 1'b1 || off0 !== 14'h0100) begin
      n_bad++; $display("FAIL ram_we got we=%b off=%h want we=1 off=0100", we0, off0);
    end
  endtask

  task automatic test_int_ack();
    int e0, e1;
    logic pr;
    do_reset();
    io_write(16'h7FFD, 8'h17, 2, 1'b0, e0, e1, pr);
    n_cmp++;
    if (e0 != 0 || p7_0 !== 8'h00) begin
      n_bad++; $display("FAIL int_ack got evt=%0d p7=%h want 0 00", e0, p7_0);
    end
  endtask

  task automatic test_reset_mid_write();
    int e0;
    do_reset();
    @(negedge clk);
    A = 16'h7FFD; D = 8'h1F; nIORQ = 1'b0; nWR = 1'b0; nM1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (p7_0 !== 8'h1F) begin
      n_bad++; $display("FAIL midrst_load got %h want 1f", p7_0);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (p7_0 !== 8'h00 || pe0 !== 1'b0) begin
      n_bad++; $display("FAIL midrst_clear got p7=%h pe=%b want 00 0", p7_0, pe0);
    end
    @(negedge clk);
    reset = 1'b0;
    e0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e0 += int'(pe0);
    end
    bus_idle();
    @(negedge clk);
    e0 += int'(pe0);
    n_cmp++;
    if (e0 != 0 || p7_0 !== 8'h00) begin
      n_bad++; $display("FAIL midrst_noload got evt=%0d p7=%h want 0 00", e0, p7_0);
    end
    for (int k = 0; k < 2; k++) begin
      mp7[k] = 8'h00;
      mp1[k] = 8'h00;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_reset();
      end else if (r < 35) begin
        logic [15:0] a;
        logic [7:0]  d;
        logic        m1, pr;
        int          e0, e1, x0, x1, orb, omb;
        bit          orom;
        case ($urandom_range(0, 3))
          0:       a = 16'h7FFD;
          1:       a = 16'h1FFD;
          2:       a = 16'($urandom);
          default: a = {2'b01, 14'($urandom)} & 16'hFFFD;
        endcase
        d = 8'($urandom);
        if ($urandom_range(0, 7) != 0) d[5] = 1'b0;
        m1 = ($urandom_range(0, 9) != 0);
        model_map(1, a, orom, orb, omb);
        io_write(a, d, $urandom_range(1, 4), m1, e0, e1, pr);
        model_write(a, d, m1, x0, x1);
        n_cmp++;
        if (pr !== orom) begin
          n_bad++; $display("FAIL rnd_old_map A=%h got %b want %b", a, pr, orom);
        end
        n_cmp++;
        if (e0 != x0 || e1 != x1) begin
          n_bad++; $display("FAIL rnd_evt A=%h D=%h got %0d/%0d want %0d/%0d", a, d, e0, e1, x0, x1);
        end
        n_cmp++;
        if (p7_0 !== mp7[0] || p1_0 !== mp1[0] || p7_1 !== mp7[1] || p1_1 !== mp1[1]) begin
          n_bad++; $display("FAIL rnd_regs got %h %h %h %h want %h %h %h %h",
                            p7_0, p1_0, p7_1, p1_1, mp7[0], mp1[0], mp7[1], mp1[1]);
        end
        n_cmp++;
        if (sb0 !== mp7[0][3] || lk0 !== mp7[0][5] || sb1 !== mp7[1][3] || lk1 !== mp7[1][5]) begin
          n_bad++; $display("FAIL rnd_flags got sb=%b%b lk=%b%b want sb=%b%b lk=%b%b",
                            sb0, sb1, lk0, lk1, mp7[0][3], mp7[1][3], mp7[0][5], mp7[1][5]);
        end
      end else begin
        logic [15:0] a;
        logic        wr;
        bit          xr0, xr1;
        int          xrb0, xmb0, xrb1, xmb1;
        a  = 16'($urandom);
        wr = 1'($urandom);
        mem_access(a, wr);
        model_map(0, a, xr0, xrb0, xmb0);
        model_map(1, a, xr1, xrb1, xmb1);
        n_cmp++;
        if (rom0 !== xr0 || rom1 !== xr1) begin
          n_bad++; $display("FAIL rnd_rom A=%h got %b/%b want %b/%b", a, rom0, rom1, xr0, xr1);
        end
        n_cmp++;
        if ((xr0 ? int'(rb0) != xrb0 : int'(mb0) != xmb0) ||
            (xr1 ? int'(rb1) != xrb1 : int'(mb1) != xmb1)) begin
          n_bad++; $display("FAIL rnd_bank A=%h got rb=%0d/%0d mb=%0d/%0d want rb=%0d/%0d mb=%0d/%0d",
                            a, rb0, rb1, mb0, mb1, xrb0, xrb1, xmb0, xmb1);
        end
        n_cmp++;
        if (we0 !== (wr && !xr0) || we1 !== (wr && !xr1) || off0 !== a[13:0] || off1 !== a[13:0]) begin
          n_bad++; $display("FAIL rnd_we A=%h wr=%b got we=%b/%b off=%h want we=%b/%b off=%h",
                            a, wr, we0, we1, off0, !xr0 && wr, !xr1 && wr, a[13:0]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    A = 16'h0000;
    D = 8'h00;
    bus_idle();
    test_reset();
    test_basic_page();
    test_lock();
    test_bank_sel();
    test_ext();
    test_rom_write();
    test_int_ack();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
